// File: rtl/out_serialiser_if.sv
// Byte-write / serial-status bundle for out_serialiser.
// master: writer side (drives load/d); slave: serialiser side.
interface out_serialiser_if;
  logic       load;
  logic [7:0] d;
  logic       tx;
  logic       busy;
  logic       full;
  logic       ovr;

  modport master (
    output load,
    output d,
    input  tx,
    input  busy,
    input  full,
    input  ovr
  );

  modport slave (
    input  load,
    input  d,
    output tx,
    output busy,
    output full,
    output ovr
  );
endinterface

// File: rtl/out_serialiser.sv
// 8N1 LSB-first serialiser with a one-byte holding register.
// Ports: CLK, RST (sync, active-high), bus (load/d in; tx/busy/full/ovr out).
module out_serialiser #(
  parameter int DIV = 4
) (
  input  logic             CLK,
  input  logic             RST,
  out_serialiser_if.slave  bus
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CMAX = CW'(DIV - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [7:0]    hold_q;
  logic [7:0]    hold_d;
  logic [7:0]    shift_q;
  logic [7:0]    shift_d;
  logic          full_q;
  logic          full_d;
  logic          ovr_q;
  logic          ovr_d;
  logic          tx_q;
  logic          tx_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [2:0]    idx_q;
  logic [2:0]    idx_d;

  logic          bit_end;
  logic          stop_end;
  logic          free;

  assign bit_end  = (cnt_q == CMAX);
  assign stop_end = (state_q == STOP) && bit_end;
  // The shifter can accept a new byte when idle or on
  // the last cycle of the stop bit (gapless chaining).
  assign free     = (state_q == IDLE) || stop_end;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      hold_q  <= '0;
      shift_q <= '0;
      full_q  <= 1'b0;
      ovr_q   <= 1'b0;
      tx_q    <= 1'b1;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      full_q  <= full_d;
      ovr_q   <= ovr_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    full_d  = full_q;
    ovr_d   = ovr_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    tx_d    = 1'b1;

    if (state_q != IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    unique case (state_q)
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
        end
      end
      default: ;
    endcase

    if (free) begin
      if (full_q) begin
        // Pending byte wins; a same-edge write refills HOLD.
        shift_d = hold_q;
        full_d  = bus.load;
        hold_d  = bus.load ? bus.d : hold_q;
        state_d = START;
        cnt_d   = '0;
      end else if (bus.load) begin
        shift_d = bus.d;
        state_d = START;
        cnt_d   = '0;
      end
    end else if (bus.load) begin
      if (full_q) begin
        ovr_d = 1'b1;
      end else begin
        hold_d = bus.d;
        full_d = 1'b1;
      end
    end

    // TX is registered: decode from the next state.
    unique case (1'b1)
      (state_d == START): tx_d = 1'b0;
      (state_d == DATA):  tx_d = shift_d[0];
      default:            tx_d = 1'b1;
    endcase
  end

  assign bus.tx   = tx_q;
  assign bus.busy = (state_q != IDLE);
  assign bus.full = full_q;
  assign bus.ovr  = ovr_q;

endmodule

// File: tb/tb_out_serialiser.sv
// Directed self-checking bench for out_serialiser.
// Main DUT at DIV=4, second instance at DIV=1.
module tb_out_serialiser;
  localparam int DIV = 4;

  logic CLK = 1'b0;
  logic RST;
  int   n_cmp = 0;
  int   n_bad = 0;

  out_serialiser_if bus();
  out_serialiser_if bus1();

  out_serialiser #(.DIV(DIV)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  out_serialiser #(.DIV(1)) dut1 (
    .CLK (CLK),
    .RST (RST),
    .bus (bus1)
  );

  always #5 CLK = ~CLK;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Checks one frame of byte b, from cycle i0 after the
  // edge that started it, up to and including edge +10*DIV.
  // Optionally writes ld_d during cycle ld_at.
  task automatic frame(string tag, logic [7:0] b, int i0,
                       int ld_at, logic [7:0] ld_d,
                       logic full0);
    logic [9:0] f;
    logic       ef;
    f = {1'b1, b, 1'b0};
    for (int i = i0; i < 10 * DIV; i++) begin
      ef = (ld_at >= 0 && i > ld_at) ? 1'b1 : full0;
      chk({tag, ".tx"}, {7'd0, bus.tx}, {7'd0, f[i / DIV]});
      chk({tag, ".busy"}, {7'd0, bus.busy}, 8'd1);
      chk({tag, ".full"}, {7'd0, bus.full}, {7'd0, ef});
      if (i == ld_at) begin
        bus.load = 1'b1;
        bus.d    = ld_d;
      end
      step();
      bus.load = 1'b0;
    end
  endtask

  initial begin
    logic [9:0]  f;
    logic [19:0] g;
    RST       = 1'b1;
    bus.load  = 1'b0;
    bus.d     = 8'h00;
    bus1.load = 1'b0;
    bus1.d    = 8'h00;

    // Reset with LOAD asserted
    bus.load = 1'b1;
    bus.d    = 8'hFF;
    step();
    step();
    chk("rst.tx", {7'd0, bus.tx}, 8'd1);
    chk("rst.busy", {7'd0, bus.busy}, 8'd0);
    chk("rst.full", {7'd0, bus.full}, 8'd0);
    chk("rst.ovr", {7'd0, bus.ovr}, 8'd0);
    RST      = 1'b0;
    bus.load = 1'b0;
    step();
    chk("rst.idle.busy", {7'd0, bus.busy}, 8'd0);
    chk("rst.idle.tx", {7'd0, bus.tx}, 8'd1);

    // Single frame 0xA5
    bus.load = 1'b1;
    bus.d    = 8'hA5;
    step();
    bus.load = 1'b0;
    frame("a5", 8'hA5, 0, -1, 8'h00, 1'b0);
    chk("a5.end.busy", {7'd0, bus.busy}, 8'd0);
    chk("a5.end.tx", {7'd0, bus.tx}, 8'd1);

    // Back-to-back 0x3C then 0xC3
    bus.load = 1'b1;
    bus.d    = 8'h3C;
    step();
    bus.load = 1'b0;
    frame("b2b0", 8'h3C, 0, 4, 8'hC3, 1'b0);
    frame("b2b1", 8'hC3, 0, -1, 8'h00, 1'b0);
    chk("b2b.end.busy", {7'd0, bus.busy}, 8'd0);
    chk("b2b.ovr", {7'd0, bus.ovr}, 8'd0);

    // Overrun: 0x11, 0x22, 0x33 on consecutive edges
    bus.load = 1'b1;
    bus.d    = 8'h11;
    step();
    bus.d    = 8'h22;
    step();
    bus.d    = 8'h33;
    step();
    bus.load = 1'b0;
    chk("ovr.set", {7'd0, bus.ovr}, 8'd1);
    frame("ovr0", 8'h11, 2, -1, 8'h00, 1'b1);
    frame("ovr1", 8'h22, 0, -1, 8'h00, 1'b0);
    chk("ovr.end.busy", {7'd0, bus.busy}, 8'd0);
    chk("ovr.sticky", {7'd0, bus.ovr}, 8'd1);

    // Stop-end race: FULL=1 and LOAD on final stop edge
    RST = 1'b1;
    step();
    RST = 1'b0;
    chk("race.ovr.clr", {7'd0, bus.ovr}, 8'd0);
    bus.load = 1'b1;
    bus.d    = 8'hAA;
    step();
    bus.d    = 8'hBB;
    step();
    bus.load = 1'b0;
    frame("race0", 8'hAA, 1, 10 * DIV - 1, 8'h55, 1'b1);
    chk("race.full", {7'd0, bus.full}, 8'd1);
    chk("race.ovr", {7'd0, bus.ovr}, 8'd0);
    frame("race1", 8'hBB, 0, -1, 8'h00, 1'b1);
    frame("race2", 8'h55, 0, -1, 8'h00, 1'b0);
    chk("race.end.busy", {7'd0, bus.busy}, 8'd0);
    chk("race.end.ovr", {7'd0, bus.ovr}, 8'd0);

    // Reset mid-frame
    bus.load = 1'b1;
    bus.d    = 8'h0F;
    step();
    bus.load = 1'b0;
    f = {1'b1, 8'h0F, 1'b0};
    for (int i = 0; i < 17; i++) begin
      chk("mid.tx", {7'd0, bus.tx}, {7'd0, f[i / DIV]});
      step();
    end
    RST      = 1'b1;
    bus.load = 1'b1;
    bus.d    = 8'hFF;
    step();
    RST      = 1'b0;
    bus.load = 1'b0;
    chk("mid.tx1", {7'd0, bus.tx}, 8'd1);
    chk("mid.busy0", {7'd0, bus.busy}, 8'd0);
    chk("mid.full0", {7'd0, bus.full}, 8'd0);
    step();
    chk("mid.noload", {7'd0, bus.busy}, 8'd0);
    bus.load = 1'b1;
    bus.d    = 8'h80;
    step();
    bus.load = 1'b0;
    frame("mid80", 8'h80, 0, -1, 8'h00, 1'b0);
    chk("mid80.end", {7'd0, bus.busy}, 8'd0);

    // DIV=1: two chained frames 0x5A then 0xC3
    g = {1'b1, 8'hC3, 1'b0, 1'b1, 8'h5A, 1'b0};
    bus1.load = 1'b1;
    bus1.d    = 8'h5A;
    step();
    bus1.d    = 8'hC3;
    step();
    bus1.load = 1'b0;
    chk("d1.full", {7'd0, bus1.full}, 8'd1);
    for (int j = 1; j < 20; j++) begin
      chk("d1.tx", {7'd0, bus1.tx}, {7'd0, g[j]});
      chk("d1.busy", {7'd0, bus1.busy}, 8'd1);
      step();
    end
    chk("d1.end.busy", {7'd0, bus1.busy}, 8'd0);
    chk("d1.end.tx", {7'd0, bus1.tx}, 8'd1);
    chk("d1.ovr", {7'd0, bus1.ovr}, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
